// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined MIPS CPU: drives the req/ready data-memory bus,
// stalls upstream while an access is outstanding, and registers the MEM/WB result.
module mem_access_stage #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUOut_in,
   input  logic [31:0] DataBusB_in,
   input  logic [31:0] PC_add_4_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic [1:0]  MemToReg_in,
   input  logic        RegWrite_in,
   input  logic [4:0]  AddrC_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall,
   output logic [31:0] WriteData_out,
   output logic        RegWrite_out,
   output logic [4:0]  AddrC_out,
   output logic        bus_error
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   state_t      state, state_next;
   logic [7:0]  wait_cnt;
   logic        access, misaligned;
   logic        start, wb_load, err_next, timeout_hit;
   logic [31:0] wb_data;

   assign access     = MemRead_in | MemWrite_in;
   assign misaligned = access & (ALUOut_in[1:0] != 2'b00);

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next  = state;
      start       = 1'b0;
      wb_load     = 1'b0;
      err_next    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!access) begin
               wb_load = 1'b1;
            end else if (misaligned) begin
               err_next = 1'b1;
            end else begin
               start      = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (mem_ready) begin
               wb_load    = 1'b1;
               state_next = IDLE;
            end else if (wait_cnt == LAST_WAIT) begin
               timeout_hit = 1'b1;
               err_next    = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Upstream must hold during the request cycle and every unanswered wait cycle.
      stall = reset & (start | ((state == ACCESS) & ~mem_ready & ~timeout_hit));
   end

   always_comb begin
      wb_data = ALUOut_in;
      case (MemToReg_in)
         2'd1:    wb_data = (state == ACCESS && mem_ready) ? mem_rdata : ALUOut_in;
         2'd2:    wb_data = PC_add_4_in;
         default: wb_data = ALUOut_in;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= (state == ACCESS && state_next == ACCESS) ? wait_cnt + 8'd1 : 8'd0;
      end
   end

   // Bus request registers: loaded on the request edge, held through ACCESS.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         bus_error <= 1'b0;
      end else begin
         bus_error <= err_next;
         if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_in;
            mem_addr  <= ALUOut_in;
            mem_wdata <= DataBusB_in;
         end else if (state == ACCESS && state_next == IDLE) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
         end
      end
   end

   // MEM/WB register: bubbles hold data/destination and only clear the write enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         WriteData_out <= '0;
         RegWrite_out  <= 1'b0;
         AddrC_out     <= '0;
      end else if (wb_load) begin
         WriteData_out <= wb_data;
         RegWrite_out  <= RegWrite_in;
         AddrC_out     <= AddrC_in;
      end else begin
         RegWrite_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expected write-back
// and bus handshakes into queues; monitors pop and compare as the DUT presents them.
module tb_mem_access_stage;

   logic        clk, reset;
   logic [31:0] ALUOut_in, DataBusB_in, PC_add_4_in, mem_rdata;
   logic        MemRead_in, MemWrite_in, RegWrite_in, mem_ready;
   logic [1:0]  MemToReg_in;
   logic [4:0]  AddrC_in;
   logic        mem_req, mem_we, stall, RegWrite_out, bus_error;
   logic [31:0] mem_addr, mem_wdata, WriteData_out;
   logic [4:0]  AddrC_out;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        err;
      logic [31:0] wd;
      logic [4:0]  ac;
   } wb_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   wb_t  wb_q[$];
   bus_t bus_q[$];
   wb_t  mon_wb;
   bus_t mon_bus;

   mem_access_stage #(.MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .ALUOut_in(ALUOut_in), .DataBusB_in(DataBusB_in), .PC_add_4_in(PC_add_4_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
      .RegWrite_in(RegWrite_in), .AddrC_in(AddrC_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
      .WriteData_out(WriteData_out), .RegWrite_out(RegWrite_out), .AddrC_out(AddrC_out),
      .bus_error(bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Write-back monitor: every MEM/WB write or error pulse must match the queue head.
   always @(posedge clk) begin
      #1;
      if (reset && (RegWrite_out || bus_error)) begin
         if (wb_q.size() == 0) begin
            check("wb_unexpected", {30'b0, RegWrite_out, bus_error}, 32'd0);
         end else begin
            mon_wb = wb_q.pop_front();
            if (mon_wb.err) begin
               check("err_pulse", {31'b0, bus_error}, 32'd1);
               check("err_regwrite", {31'b0, RegWrite_out}, 32'd0);
            end else begin
               check("wb_data", WriteData_out, mon_wb.wd);
               check("wb_addr", {27'b0, AddrC_out}, {27'b0, mon_wb.ac});
               check("wb_no_err", {31'b0, bus_error}, 32'd0);
            end
         end
      end
   end

   // Bus monitor: each completed handshake must match the expected request.
   always @(negedge clk) begin
      #2;
      if (reset && mem_req && mem_ready) begin
         if (bus_q.size() == 0) begin
            check("bus_unexpected", mem_addr, 32'hFFFF_FFFF);
         end else begin
            mon_bus = bus_q.pop_front();
            check("bus_we", {31'b0, mem_we}, {31'b0, mon_bus.we});
            check("bus_addr", mem_addr, mon_bus.addr);
            check("bus_wdata", mem_wdata, mon_bus.wdata);
         end
      end
   end

   task automatic set_nop();
      MemRead_in  = 1'b0;
      MemWrite_in = 1'b0;
      RegWrite_in = 1'b0;
      mem_ready   = 1'b0;
   endtask

   // One EX/MEM op held until stall drops; waits < 0 means mem_ready never comes.
   task automatic do_op(input string name, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                        input logic [1:0] m2r, input logic rw, input logic [4:0] ac,
                        input int waits, input logic [31:0] rdata,
                        input int exp_stall, input int exp_req);
      int  stalls = 0;
      int  req_cycles = 0;
      bit  done = 0;
      @(negedge clk);
      MemRead_in  = rd;
      MemWrite_in = wr;
      ALUOut_in   = alu;
      DataBusB_in = wd;
      PC_add_4_in = pc4;
      MemToReg_in = m2r;
      RegWrite_in = rw;
      AddrC_in    = ac;
      mem_rdata   = rdata;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (mem_req) begin
            req_cycles++;
            mem_ready = (waits >= 0) && (req_cycles == waits + 1);
         end else begin
            mem_ready = 1'b0;
         end
         #1;
         if (stall) stalls++;
         else done = 1;
      end
      if (!done) check({name, "_hung"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
      set_nop();
      check({name, "_stall_cycles"}, stalls, exp_stall);
      check({name, "_req_cycles"}, req_cycles, exp_req);
   endtask

   function automatic wb_t wb_ok(input logic [31:0] wd, input logic [4:0] ac);
      wb_t e;
      e.err = 1'b0;
      e.wd  = wd;
      e.ac  = ac;
      return e;
   endfunction

   function automatic wb_t wb_err();
      wb_t e;
      e.err = 1'b1;
      e.wd  = '0;
      e.ac  = '0;
      return e;
   endfunction

   function automatic bus_t bus_exp(input logic we, input logic [31:0] a, input logic [31:0] d);
      bus_t b;
      b.we    = we;
      b.addr  = a;
      b.wdata = d;
      return b;
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "global timeout");
   end

   initial begin
      reset       = 1'b0;
      ALUOut_in   = '0;
      DataBusB_in = '0;
      PC_add_4_in = '0;
      MemToReg_in = '0;
      AddrC_in    = '0;
      mem_rdata   = '0;
      set_nop();
      #12;
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_wb_data", WriteData_out, 32'd0);
      check("rst_regwrite", {31'b0, RegWrite_out}, 32'd0);
      check("rst_bus_error", {31'b0, bus_error}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Pass-through ALU, PC+4 and select-3 values.
      wb_q.push_back(wb_ok(32'h0000_1234, 5'd8));
      do_op("pass_alu", 0, 0, 32'h1234, 32'h0, 32'h0, 2'd0, 1, 5'd8, 0, 32'h0, 0, 0);
      wb_q.push_back(wb_ok(32'h0040_0044, 5'd31));
      do_op("pass_pc4", 0, 0, 32'h5678, 32'h0, 32'h0040_0044, 2'd2, 1, 5'd31, 0, 32'h0, 0, 0);
      wb_q.push_back(wb_ok(32'h0000_ABCD, 5'd7));
      do_op("pass_sel3", 0, 0, 32'hABCD, 32'h0, 32'h0, 2'd3, 1, 5'd7, 0, 32'h0, 0, 0);

      // Load with two wait cycles: 3 stall cycles, 3 request cycles.
      bus_q.push_back(bus_exp(1'b0, 32'h100, 32'h0));
      wb_q.push_back(wb_ok(32'hDEAD_BEEF, 5'd9));
      do_op("load_w2", 1, 0, 32'h100, 32'h0, 32'h0, 2'd1, 1, 5'd9, 2, 32'hDEAD_BEEF, 3, 3);

      // Store with immediate ready and RegWrite_in = 0: no write-back.
      bus_q.push_back(bus_exp(1'b1, 32'h200, 32'hCAFE_0001));
      do_op("store", 0, 1, 32'h200, 32'hCAFE_0001, 32'h0, 2'd0, 0, 5'd3, 0, 32'h0, 1, 1);

      // Read and write together behave as a write.
      bus_q.push_back(bus_exp(1'b1, 32'h300, 32'h55AA_55AA));
      wb_q.push_back(wb_ok(32'h0000_0300, 5'd10));
      do_op("rd_wr", 1, 1, 32'h300, 32'h55AA_55AA, 32'h0, 2'd0, 1, 5'd10, 1, 32'h99, 2, 2);

      // Load selecting the ALU result ignores rdata.
      bus_q.push_back(bus_exp(1'b0, 32'h10C, 32'h0));
      wb_q.push_back(wb_ok(32'h0000_010C, 5'd5));
      do_op("load_alu", 1, 0, 32'h10C, 32'h0, 32'h0, 2'd0, 1, 5'd5, 0, 32'h77, 1, 1);

      // Ready arrives on the last allowed wait cycle: completes, no error.
      bus_q.push_back(bus_exp(1'b0, 32'h110, 32'h0));
      wb_q.push_back(wb_ok(32'h0BAD_F00D, 5'd6));
      do_op("load_w3", 1, 0, 32'h110, 32'h0, 32'h0, 2'd1, 1, 5'd6, 3, 32'h0BAD_F00D, 4, 4);

      // Misaligned load: no request, single error pulse, bubble.
      wb_q.push_back(wb_err());
      do_op("misaligned", 1, 0, 32'h102, 32'h0, 32'h0, 2'd1, 1, 5'd11, 0, 32'h0, 0, 0);

      // Timeout: four unanswered ACCESS cycles abort the load.
      wb_q.push_back(wb_err());
      do_op("timeout", 1, 0, 32'h104, 32'h0, 32'h0, 2'd1, 1, 5'd12, -1, 32'h0, 4, 4);
      check("timeout_req_dropped", {31'b0, mem_req}, 32'd0);

      // Reset during the second ACCESS cycle.
      @(negedge clk);
      MemRead_in  = 1'b1;
      ALUOut_in   = 32'h180;
      MemToReg_in = 2'd1;
      RegWrite_in = 1'b1;
      AddrC_in    = 5'd13;
      @(negedge clk);
      @(negedge clk);
      check("mid_req_active", {31'b0, mem_req}, 32'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_req", {31'b0, mem_req}, 32'd0);
      check("mid_rst_stall", {31'b0, stall}, 32'd0);
      check("mid_rst_addr", mem_addr, 32'd0);
      check("mid_rst_wb_data", WriteData_out, 32'd0);
      check("mid_rst_addrc", {27'b0, AddrC_out}, 32'd0);
      set_nop();
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("late_ready_regwrite", {31'b0, RegWrite_out}, 32'd0);
      check("late_ready_req", {31'b0, mem_req}, 32'd0);

      repeat (3) @(negedge clk);
      check("wb_queue_empty", wb_q.size(), 32'd0);
      check("bus_queue_empty", bus_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
